// File: rtl/fft_peak_detect.sv
// fft_peak_detect: consumes one streamed FFT frame and reports the strongest
// bin (index, power, note-present flag) inside a fixed search window. Frames
// with a misplaced SOP or EOP are dropped and flagged with frame_error.
//
// Handshake: a beat transfers in a cycle where source_valid && source_ready are
// both high. source_ready is low only while reset is asserted, so the block
// never back-pressures. Data and sideband are sampled only on an accepted beat.
module fft_peak_detect #(
  parameter int          FFT_LEN   = 1024,
  parameter int          DATA_W    = 25,
  parameter int          BIN_W     = 10,
  parameter int          MIN_BIN   = 1,
  parameter int          MAX_BIN   = 511,
  parameter int unsigned THRESHOLD = 1 << 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     source_valid,
  output logic                     source_ready,
  input  logic                     source_sop,
  input  logic                     source_eop,
  input  logic signed [DATA_W-1:0] source_real,
  input  logic signed [DATA_W-1:0] source_imag,
  output logic                     peak_valid,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [2*DATA_W:0]        peak_power,
  output logic                     note_present,
  output logic                     frame_error,
  output logic                     dbg_state_o
);

  localparam int              PW     = 2 * DATA_W + 1;
  localparam logic [BIN_W-1:0] LAST  = BIN_W'(FFT_LEN - 1);
  localparam logic [BIN_W-1:0] MIN_B = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_BIN);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   cnt_q, cnt_d;      // index of the next expected beat
  logic               err_q;

  logic               acc, take, first, last, err;
  logic [BIN_W-1:0]   idx;

  // Stage 1: squares plus per-beat tags
  logic               s1_valid_q, s1_first_q, s1_last_q, s1_win_q;
  logic [BIN_W-1:0]   s1_bin_q;
  logic [PW-2:0]      re2_q, im2_q;
  logic signed [PW-2:0] re_ext, im_ext;

  // Stage 2: power plus tags
  logic               s2_valid_q, s2_first_q, s2_last_q, s2_win_q;
  logic [BIN_W-1:0]   s2_bin_q;
  logic [PW-1:0]      pwr_q;

  // Running maximum and the candidate after this cycle's compare
  logic [PW-1:0]      max_pwr_q, base_pwr, new_pwr;
  logic [BIN_W-1:0]   max_bin_q, base_bin, new_bin;

  logic               pv_q, note_q;
  logic [BIN_W-1:0]   pbin_q;
  logic [PW-1:0]      ppwr_q;

  assign source_ready = ~reset;
  assign acc          = source_valid & source_ready;
  assign re_ext       = {{DATA_W{source_real[DATA_W-1]}}, source_real};
  assign im_ext       = {{DATA_W{source_imag[DATA_W-1]}}, source_imag};

  // Beat decode: bin index, frame tags, errors and next FSM state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    err     = 1'b0;
    idx     = cnt_q;
    if (acc) begin
      case (state_q)
        IDLE: begin
          if (source_sop) begin
            take    = 1'b1;
            first   = 1'b1;
            idx     = '0;
            cnt_d   = BIN_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          take = 1'b1;
          if (source_sop) begin
            // Mid-frame SOP (also SOP+EOP): restart on this beat as bin 0
            err   = 1'b1;
            first = 1'b1;
            idx   = '0;
            cnt_d = BIN_W'(1);
          end else if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (source_eop) last = 1'b1;
            else            err  = 1'b1;
          end else if (source_eop) begin
            err     = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BIN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame FSM with registered error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err;
    end
  end

  // Pipeline valid bits and tags; cleared by reset to drop in-flight beats
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= take;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Pipeline datapath: squares, then a full-width sum
  always_ff @(posedge clk) begin
    s1_first_q <= first;
    s1_last_q  <= last;
    s1_win_q   <= (idx >= MIN_B) && (idx <= MAX_B);
    s1_bin_q   <= idx;
    re2_q      <= $unsigned(re_ext * re_ext);
    im2_q      <= $unsigned(im_ext * im_ext);
    s2_first_q <= s1_first_q;
    s2_last_q  <= s1_last_q;
    s2_win_q   <= s1_win_q;
    s2_bin_q   <= s1_bin_q;
    pwr_q      <= {1'b0, re2_q} + {1'b0, im2_q};
  end

  // Compare against the running max; a frame-start beat compares against a cleared max
  always_comb begin
    base_pwr = s2_first_q ? '0 : max_pwr_q;
    base_bin = s2_first_q ? MIN_B : max_bin_q;
    new_pwr  = base_pwr;
    new_bin  = base_bin;
    if (s2_win_q && (pwr_q > base_pwr)) begin
      new_pwr = pwr_q;
      new_bin = s2_bin_q;
    end
  end

  // Running max update and result publication on the tagged last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      max_pwr_q <= '0;
      max_bin_q <= MIN_B;
      pv_q      <= 1'b0;
      pbin_q    <= '0;
      ppwr_q    <= '0;
      note_q    <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (s2_valid_q) begin
        max_pwr_q <= new_pwr;
        max_bin_q <= new_bin;
        if (s2_last_q) begin
          pv_q   <= 1'b1;
          pbin_q <= new_bin;
          ppwr_q <= new_pwr;
          note_q <= (new_pwr >= PW'(THRESHOLD));
        end
      end
    end
  end

  assign peak_valid   = pv_q;
  assign peak_bin     = pbin_q;
  assign peak_power   = ppwr_q;
  assign note_present = note_q;
  assign frame_error  = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: single tone, tie, window edges, extreme
// values, malformed frames, back-to-back frames with gaps and mid-frame reset.
module tb_fft_peak_detect;

  localparam int N  = 1024;
  localparam int DW = 25;
  localparam int BW = 10;
  localparam int PW = 2 * DW + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 source_valid, source_sop, source_eop;
  logic                 source_ready;
  logic signed [DW-1:0] source_real, source_imag;
  logic                 peak_valid, note_present, frame_error, dbg_state;
  logic [BW-1:0]        peak_bin;
  logic [PW-1:0]        peak_power;

  fft_peak_detect dut (
    .clk          (clk),
    .reset        (reset),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .peak_valid   (peak_valid),
    .peak_bin     (peak_bin),
    .peak_power   (peak_power),
    .note_present (note_present),
    .frame_error  (frame_error),
    .dbg_state_o  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int pv_cnt   = 0;
  int eop_cyc  = 0;

  logic signed [DW-1:0] re_a [N];
  logic signed [DW-1:0] im_a [N];

  // Scoreboard entry: {note, power, bin}
  logic [PW+BW:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_frame();
    for (int i = 0; i < N; i++) begin
      re_a[i] = '0;
      im_a[i] = '0;
    end
  endtask

  task automatic exp_push(input int bin, input logic [PW-1:0] pwr, input bit note);
    exp_q.push_back({note, pwr, BW'(bin)});
  endtask

  // Drive n beats from re_a/im_a; SOP on beat 0, EOP on beat eop_at (-1 = none)
  task automatic send_frame(input int n, input int eop_at, input bit gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          source_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      source_valid = 1'b1;
      source_sop   = (i == 0);
      source_eop   = (i == eop_at);
      source_real  = re_a[i];
      source_imag  = im_a[i];
      @(posedge clk); #1;
      if (i == eop_at) eop_cyc = cyc;
    end
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Result monitor: pop expected result on every peak_valid pulse
  always @(negedge clk) begin
    logic [PW+BW:0] e;
    if (!reset) begin
      if (frame_error) err_cnt++;
      if (peak_valid) begin
        pv_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_pv", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pv_bin",  peak_bin,      e[BW-1:0]);
          check("pv_pwr",  peak_power,    e[PW+BW-1:BW]);
          check("pv_note", note_present,  e[PW+BW]);
          check("pv_lat",  cyc - eop_cyc, 2);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    source_real  = '0;
    source_imag  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", source_ready, 0);
    check("rst_pv",    peak_valid,   0);
    check("rst_bin",   peak_bin,     0);
    check("rst_pwr",   peak_power,   0);
    check("rst_note",  note_present, 0);
    check("rst_ferr",  frame_error,  0);
    check("rst_state", dbg_state,    0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("ready_up", source_ready, 1);

    // Single tone at bin 37: 1000^2 + 2000^2
    clr_frame(); re_a[37] = 1000; im_a[37] = -2000;
    exp_push(37, 51'd5000000, 1'b1);
    send_frame(N, N - 1, 1'b0);
    wait_drain();

    // Tie: lower bin wins
    clr_frame(); re_a[40] = 3000; im_a[40] = 4000; re_a[90] = 3000; im_a[90] = 4000;
    exp_push(40, 51'd25000000, 1'b1);
    send_frame(N, N - 1, 1'b0);
    wait_drain();

    // Window exclusion of DC and bins above MAX_BIN; result below threshold
    clr_frame(); re_a[0] = 30000; re_a[600] = 30000; re_a[5] = 100;
    exp_push(5, 51'd10000, 1'b0);
    send_frame(N, N - 1, 1'b0);
    wait_drain();

    // Extreme negative inputs: 2 * 2^48 with no overflow
    clr_frame(); re_a[10] = -(1 << 24); im_a[10] = -(1 << 24);
    exp_push(10, 51'd1 << 49, 1'b1);
    send_frame(N, N - 1, 1'b0);
    wait_drain();

    // Early EOP at bin 500: error, outputs held
    clr_frame(); re_a[7] = 20000;
    send_frame(501, 500, 1'b0);
    repeat (6) @(posedge clk); #1;
    check("eop500_ferr", err_cnt, 1);
    check("eop500_bin",  peak_bin, 10);
    check("eop500_pwr",  peak_power, 64'd1 << 49);
    check("eop500_idle", dbg_state, 0);

    // Full-length frame with EOP missing on the last bin
    send_frame(N, -1, 1'b0);
    repeat (6) @(posedge clk); #1;
    check("noeop_ferr", err_cnt, 2);
    check("noeop_bin",  peak_bin, 10);

    // SOP at bin 200 restarts; the partial frame's strong bin must be discarded
    clr_frame(); re_a[50] = 20000;
    send_frame(200, -1, 1'b0);
    clr_frame(); re_a[77] = 500; im_a[77] = 500;
    exp_push(77, 51'd500000, 1'b0);
    send_frame(N, N - 1, 1'b0);
    wait_drain();
    check("sop200_ferr", err_cnt, 3);

    // Back-to-back frames with random valid gaps
    clr_frame(); re_a[37] = 1000; im_a[37] = -2000;
    exp_push(37, 51'd5000000, 1'b1);
    send_frame(N, N - 1, 1'b1);
    clr_frame(); re_a[100] = 2000;
    exp_push(100, 51'd4000000, 1'b1);
    send_frame(N, N - 1, 1'b1);
    wait_drain();

    // Reset in the middle of a third frame
    clr_frame(); re_a[5] = 30000;
    send_frame(300, -1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_ready", source_ready, 0);
    check("mrst_bin",   peak_bin,     0);
    check("mrst_pwr",   peak_power,   0);
    check("mrst_note",  note_present, 0);
    check("mrst_state", dbg_state,    0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("mrst_ferr",  err_cnt, 3);
    check("pv_total",   pv_cnt,  7);
    check("sb_empty",   exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    check("timeout", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
